vc_phase_sequencer: RTL and testbench

VC_PHASE_SEQUENCER -- requirements
Module: vc_phase_sequencer

---
 rtl/vc_phase_sequencer.sv | 167 ++++++++++++++++
 tb/tb_vc_phase_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vc_phase_sequencer.sv
// Four-phase A/AB/B/BA crossfade sequencer with tick-based phase timing and gain ramp.
// All outputs registered; phase config is double-buffered and takes effect at each cycle start.
module vc_phase_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        cfg_load,
  input  logic [15:0] dur_a,
  input  logic [15:0] dur_ab,
  input  logic [15:0] dur_b,
  input  logic [15:0] dur_ba,
  input  logic [9:0]  step,
  output logic [1:0]  phase,
  output logic [3:0]  T,
  output logic        busy,
  output logic [9:0]  gain_b,
  output logic        wrap
);

  typedef enum logic [2:0] {S_IDLE, S_A, S_AB, S_B, S_BA} state_t;

  state_t            state, state_n;
  logic [15:0]       cnt, cnt_n;
  logic [3:0][15:0]  sh_dur, act_dur, cfg_dur, ld_dur;
  logic [9:0]        sh_step, act_step, ld_step;
  logic [15:0]       cur_dur, last_cnt;
  logic              done, copy;
  logic [10:0]       sum, diff;
  logic [1:0]        phase_n;
  logic [3:0]        t_n;
  logic              busy_n, wrap_n;
  logic [9:0]        gain_n;

  always_comb begin
    cfg_dur  = {dur_ba, dur_b, dur_ab, dur_a};
    // A load on the same clock as a cycle start must reach the active set directly.
    ld_dur   = cfg_load ? cfg_dur : sh_dur;
    ld_step  = cfg_load ? step : sh_step;

    case (state)
      S_A:     cur_dur = act_dur[0];
      S_AB:    cur_dur = act_dur[1];
      S_B:     cur_dur = act_dur[2];
      S_BA:    cur_dur = act_dur[3];
      default: cur_dur = act_dur[0];
    endcase
    last_cnt = (cur_dur == 16'd0) ? 16'd0 : cur_dur - 16'd1;
    done     = tick && (cnt == last_cnt);
    sum      = {1'b0, gain_b} + {1'b0, act_step};
    diff     = {1'b0, gain_b} - {1'b0, act_step};
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gain_n  = gain_b;
    wrap_n  = 1'b0;
    copy    = 1'b0;
    phase_n = 2'b00;
    t_n     = 4'b0000;
    busy_n  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_n = S_A;
          cnt_n   = '0;
          gain_n  = '0;
          copy    = 1'b1;
        end
      end
      S_A: begin
        gain_n = '0;
        if (done) begin
          state_n = S_AB;
          cnt_n   = '0;
        end else if (tick) begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_AB: begin
        if (tick) gain_n = sum[10] ? 10'd1023 : sum[9:0];
        if (done) begin
          state_n = S_B;
          cnt_n   = '0;
          gain_n  = 10'd1023;
        end else if (tick) begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_B: begin
        gain_n = 10'd1023;
        if (done) begin
          state_n = S_BA;
          cnt_n   = '0;
        end else if (tick) begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_BA: begin
        // Borrow out of bit 10 means the subtraction went below zero.
        if (tick) gain_n = diff[10] ? 10'd0 : diff[9:0];
        if (done) begin
          state_n = S_A;
          cnt_n   = '0;
          gain_n  = '0;
          wrap_n  = 1'b1;
          copy    = 1'b1;
        end else if (tick) begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (state != S_IDLE && stop) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      gain_n  = '0;
      wrap_n  = 1'b0;
      copy    = 1'b0;
    end

    case (state_n)
      S_A:     begin phase_n = 2'b00; t_n = 4'b0001; busy_n = 1'b1; end
      S_AB:    begin phase_n = 2'b01; t_n = 4'b0010; busy_n = 1'b1; end
      S_B:     begin phase_n = 2'b10; t_n = 4'b0100; busy_n = 1'b1; end
      S_BA:    begin phase_n = 2'b11; t_n = 4'b1000; busy_n = 1'b1; end
      default: begin phase_n = 2'b00; t_n = 4'b0000; busy_n = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      phase    <= 2'b00;
      T        <= 4'b0000;
      busy     <= 1'b0;
      gain_b   <= '0;
      wrap     <= 1'b0;
      sh_dur   <= {4{16'd1}};
      act_dur  <= {4{16'd1}};
      sh_step  <= '0;
      act_step <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      phase  <= phase_n;
      T      <= t_n;
      busy   <= busy_n;
      gain_b <= gain_n;
      wrap   <= wrap_n;
      if (cfg_load) begin
        sh_dur  <= cfg_dur;
        sh_step <= step;
      end
      if (copy) begin
        act_dur  <= ld_dur;
        act_step <= ld_step;
      end
    end
  end

endmodule

// File: tb/tb_vc_phase_sequencer.sv
// Directed bench for vc_phase_sequencer: phase timing, gain ramps, config buffering, stop and reset.
module tb_vc_phase_sequencer;
  logic        clk = 1'b0;
  logic        rst, tick, start, stop, cfg_load;
  logic [15:0] dur_a, dur_ab, dur_b, dur_ba;
  logic [9:0]  step;
  logic [1:0]  phase;
  logic [3:0]  T;
  logic        busy;
  logic [9:0]  gain_b;
  logic        wrap;

  int tests = 0;
  int fails = 0;

  vc_phase_sequencer dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .cfg_load(cfg_load),
    .dur_a(dur_a), .dur_ab(dur_ab), .dur_b(dur_b), .dur_ba(dur_ba), .step(step),
    .phase(phase), .T(T), .busy(busy), .gain_b(gain_b), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full output check; phase and busy follow from the expected one-hot T.
  task automatic chk_all(input string tag, input logic [3:0] et, input logic [9:0] eg, input logic ew);
    logic [1:0]  ep;
    logic [17:0] obs, exp;
    case (et)
      4'b0010: ep = 2'b01;
      4'b0100: ep = 2'b10;
      4'b1000: ep = 2'b11;
      default: ep = 2'b00;
    endcase
    obs = {phase, T, busy, gain_b, wrap};
    exp = {ep, et, (et != 4'b0000), eg, ew};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed phase/T/busy/gain/wrap=%b/%b/%b/%0d/%b expected=%b/%b/%b/%0d/%b",
             tag, phase, T, busy, gain_b, wrap, ep, et, (et != 4'b0000), eg, ew);
    end
  endtask

  task automatic run(input string tag, input int n, input logic [3:0] et);
    for (int i = 0; i < n; i++) begin
      cyc();
      tests++;
      assert (T === et) else begin
        fails++;
        $error("FAIL %s[%0d] observed T=%b expected=%b", tag, i, T, et);
      end
    end
  endtask

  task automatic load(input logic [15:0] a, ab, b, ba, input logic [9:0] s);
    dur_a = a; dur_ab = ab; dur_b = b; dur_ba = ba; step = s;
    cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
  endtask

  logic [3:0] e_t [15];
  logic [9:0] e_g [15];
  logic       e_w [15];

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; cfg_load = 1'b0;
    dur_a = 16'd0; dur_ab = 16'd0; dur_b = 16'd0; dur_ba = 16'd0; step = 10'd0;
    repeat (3) cyc();
    chk_all("reset", 4'b0000, 10'd0, 1'b0);
    rst = 1'b0;
    cyc();
    chk_all("idle_after_reset", 4'b0000, 10'd0, 1'b0);

    // Basic cycle 3/4/3/4 with step 256, tick every clock.
    tick = 1'b1;
    load(16'd3, 16'd4, 16'd3, 16'd4, 10'd256);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk_all("enter_a", 4'b0001, 10'd0, 1'b0);
    e_t = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h8, 4'h8, 4'h8, 4'h8, 4'h1, 4'h1};
    e_g = '{10'd0, 10'd0, 10'd0, 10'd256, 10'd512, 10'd768, 10'd1023, 10'd1023, 10'd1023,
            10'd1023, 10'd767, 10'd511, 10'd255, 10'd0, 10'd0};
    e_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk_all($sformatf("cycle1_%0d", i), e_t[i], e_g[i], e_w[i]);
    end

    // dur_a reload during B must not disturb the running cycle.
    run("a3", 1, 4'b0001);
    run("ab", 4, 4'b0010);
    run("b1", 1, 4'b0100);
    dur_a = 16'd10; cfg_load = 1'b1;
    run("b2_load", 1, 4'b0100);
    cfg_load = 1'b0;
    run("b3", 1, 4'b0100);
    run("ba_old", 4, 4'b1000);
    cyc();
    chk_all("wrap2", 4'b0001, 10'd0, 1'b1);
    // New A length of 10 ticks, with three tickless clocks that must not count.
    for (int i = 0; i < 12; i++) begin
      tick = (i >= 2 && i < 5) ? 1'b0 : 1'b1;
      cyc();
      chk_all($sformatf("a10_%0d", i), 4'b0001, 10'd0, 1'b0);
    end
    tick = 1'b1;
    cyc();
    chk_all("ab_after_a10", 4'b0010, 10'd0, 1'b0);
    tick = 1'b0;
    cyc();
    chk_all("ab_no_tick", 4'b0010, 10'd0, 1'b0);
    tick = 1'b1;
    cyc();
    chk_all("ab_tick", 4'b0010, 10'd256, 1'b0);

    // Stop mid-ramp.
    stop = 1'b1;
    cyc();
    chk_all("stop_ab", 4'b0000, 10'd0, 1'b0);
    // start and stop together in IDLE stay idle.
    start = 1'b1;
    cyc();
    chk_all("start_stop_idle1", 4'b0000, 10'd0, 1'b0);
    cyc();
    chk_all("start_stop_idle2", 4'b0000, 10'd0, 1'b0);
    start = 1'b0; stop = 1'b0;

    // Saturation with step 600 in both ramps.
    load(16'd1, 16'd4, 16'd1, 16'd4, 10'd600);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk_all("sat_a", 4'b0001, 10'd0, 1'b0);
    e_t = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h8, 4'h8, 4'h8, 4'h8, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h4};
    e_g = '{10'd0, 10'd600, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd423, 10'd0, 10'd0,
            10'd0, 10'd0, 10'd600, 10'd1023, 10'd1023, 10'd1023};
    e_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk_all($sformatf("sat_%0d", i), e_t[i], e_g[i], e_w[i]);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk_all("stop_b", 4'b0000, 10'd0, 1'b0);

    // Zero durations behave as one tick each.
    load(16'd0, 16'd0, 16'd0, 16'd0, 10'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk_all("zero_a", 4'b0001, 10'd0, 1'b0);
    cyc(); chk_all("zero_ab", 4'b0010, 10'd0, 1'b0);
    cyc(); chk_all("zero_b", 4'b0100, 10'd1023, 1'b0);
    cyc(); chk_all("zero_ba", 4'b1000, 10'd1023, 1'b0);
    cyc(); chk_all("zero_wrap", 4'b0001, 10'd0, 1'b1);
    cyc(); chk_all("zero_ab2", 4'b0010, 10'd0, 1'b0);
    cyc(); chk_all("zero_b2", 4'b0100, 10'd1023, 1'b0);
    cyc(); chk_all("zero_ba2", 4'b1000, 10'd1023, 1'b0);

    // Reset in BA on its completing tick: no wrap, all outputs at reset values.
    rst = 1'b1;
    cyc();
    chk_all("rst_in_ba", 4'b0000, 10'd0, 1'b0);
    rst = 1'b0;
    cyc();
    chk_all("idle_after_rst", 4'b0000, 10'd0, 1'b0);
    cyc();
    chk_all("idle_after_rst2", 4'b0000, 10'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
